div_seq: RTL and testbench

Multi-cycle 32-bit divide sequencer for the five-stage core, serving the DIV/DIVU path of the execute stage. EX presents operands and holds `start_i` high while it stalls the pipeline. The block runs a 32-step restoring division and returns `{remainder, quotient}` for the HI/LO write-back path. It also reports busy status so the pipeline stall controller can freeze the front end.

---
 rtl/div_seq.sv | 162 ++++++++++++++++
 tb/tb_div_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//
// Multi-cycle restoring divider for the DIV/DIVU path of the execute stage.
// EX holds start_i high while it stalls the pipeline. The block runs one
// restoring-division step per cycle and returns {remainder, quotient} for
// the HI/LO write-back path.
//
// Ports
//   clk           core clock, all state updates on the rising edge
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU; sampled in FREE
//   opdata1_i     dividend; sampled in FREE
//   opdata2_i     divisor; sampled in FREE
//   start_i       request level, held high until ready_o has been consumed
//   annul_i       cancel request (flush/exception), wins over start_i
//   result_o      {remainder, quotient}; upper half to HI, lower half to LO
//   ready_o       result valid, high for the whole END state
//   busy_o        registered, high while dividing or handling divide-by-zero
// ---------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   // Counter must hold the value WIDTH itself (32 needs 6 bits).
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_FREE,
      ST_BYZERO,
      ST_ON,
      ST_END
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             qneg;
   logic             rneg;

   logic [WIDTH-1:0] op1_abs;
   logic [WIDTH-1:0] op2_abs;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quo_final;
   logic [WIDTH-1:0] rem_final;

   // Magnitudes are only taken for signed operations with a negative operand.
   assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // Trial subtraction of the shifted partial remainder. Its top bit is the
   // borrow: when clear, the subtraction fits and a quotient 1 is produced.
   // The partial remainder is always smaller than the divisor, so the stored
   // remainder never needs that extra bit; only the trial result carries it.
   assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

   // Sign fix-up of the unsigned magnitudes, two's complement mod 2^WIDTH.
   // This makes 0x80000000 / 0xFFFFFFFF wrap to 0x80000000 without a trap.
   assign quo_final = qneg ? -quo : quo;
   assign rem_final = rneg ? -rem : rem;

   // Sequencer: FREE samples the request, ON does one restoring step per
   // cycle, BYZERO short-circuits a zero divisor, END holds the result until
   // EX drops start_i. busy/ready are registered alongside the state so they
   // change on the same edge as the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_FREE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         qneg     <= 1'b0;
         rneg     <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         case (state)
            ST_FREE: begin
               if (annul_i) begin
                  state  <= ST_FREE;
                  busy_o <= 1'b0;
               end else if (start_i && (opdata2_i == '0)) begin
                  state  <= ST_BYZERO;
                  busy_o <= 1'b1;
               end else if (start_i) begin
                  state  <= ST_ON;
                  busy_o <= 1'b1;
                  cnt    <= '0;
                  rem    <= '0;
                  quo    <= op1_abs;
                  dvs    <= op2_abs;
                  qneg   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  rneg   <= signed_div_i & opdata1_i[WIDTH-1];
               end
            end

            ST_BYZERO: begin
               busy_o <= 1'b0;
               if (annul_i) begin
                  state <= ST_FREE;
               end else begin
                  state    <= ST_END;
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end

            ST_ON: begin
               if (annul_i) begin
                  // Cancelled work leaves the previous result visible.
                  state  <= ST_FREE;
                  busy_o <= 1'b0;
               end else if (cnt != CW'(WIDTH)) begin
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
               end else begin
                  state    <= ST_END;
                  busy_o   <= 1'b0;
                  ready_o  <= 1'b1;
                  result_o <= {rem_final, quo_final};
               end
            end

            ST_END: begin
               // A flush here is treated the same as EX releasing the request.
               if (!start_i || annul_i) begin
                  state   <= ST_FREE;
                  ready_o <= 1'b0;
               end
            end

            default: begin
               state   <= ST_FREE;
               busy_o  <= 1'b0;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
//
// Self-checking bench for div_seq: a table of fixed vectors, randomized
// operations checked against an arithmetic reference model, and hand-written
// sequences for annul, asynchronous reset and holding start_i in END.
// ---------------------------------------------------------------------------
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   div_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   // Reference: 64-bit truncating division on the operands interpreted as
   // signed or unsigned values; a zero divisor yields an all-zero result.
   function automatic logic [63:0] refModel(input logic sd, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one full request: start, wait for ready (bounded), optionally keep
   // start_i high in END for 'hold' cycles, then release and check FREE.
   // Operands are scrambled while the division runs; they must be ignored.
   task automatic applyStimulus(input string name, input logic sd,
                                input logic [31:0] a, input logic [31:0] b,
                                input int hold, input logic [63:0] exp);
      logic [63:0] res;
      int          lat;
      int          exp_lat;
      exp_lat      = (b == 32'd0) ? 1 : 33;
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, " busy_after_start"}, 64'(busy_o), 64'd1);
      lat = 0;
      while (!ready_o && lat < 100) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({name, " result"}, result_o, exp);
      checkOutput({name, " busy_at_ready"}, 64'(busy_o), 64'd0);
      res = result_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({name, " ready_held"}, 64'(ready_o), 64'd1);
         checkOutput({name, " result_held"}, result_o, res);
      end
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, " ready_after_drop"}, 64'(ready_o), 64'd0);
      checkOutput({name, " busy_after_drop"}, 64'(busy_o), 64'd0);
      checkOutput({name, " result_kept"}, result_o, res);
   endtask

   // ready_o and busy_o must never be high together.
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (ready_o && busy_o) begin
            errors++;
            $display("[TB] FAIL ready_busy_overlap: ready=%b busy=%b, expected not both 1",
                     ready_o, busy_o);
         end
      end
   end

   initial begin
      logic [63:0] prev;
      logic        saw_ready;
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;

      vecs[0] = '{"divu_100_7",      1'b0, 32'd100,      32'd7,        {32'h00000002, 32'h0000000E}};
      vecs[1] = '{"div_m7_2",        1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
      vecs[2] = '{"div_7_m2",        1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
      vecs[3] = '{"div_min_m1",      1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
      vecs[4] = '{"divu_max_1",      1'b0, 32'hFFFFFFFF, 32'd1,        {32'h00000000, 32'hFFFFFFFF}};
      vecs[5] = '{"divu_by_zero",    1'b0, 32'd12345,    32'd0,        64'd0};
      vecs[6] = '{"div_by_zero",     1'b1, 32'hFFFFFFF9, 32'd0,        64'd0};
      vecs[7] = '{"divu_0_5",        1'b0, 32'd0,        32'd5,        64'd0};

      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_result", result_o, 64'd0);
      checkOutput("reset_ready", 64'(ready_o), 64'd0);
      checkOutput("reset_busy", 64'(busy_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         applyStimulus(vecs[i].name, vecs[i].sd, vecs[i].a, vecs[i].b, 0, vecs[i].exp);

      for (int i = 0; i < 40; i++) begin
         sd = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = 32'($urandom_range(1, 255));
            2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 255));
            default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> 16);
         endcase
         applyStimulus("random", sd, a, b, 0, refModel(sd, a, b));
      end

      // Annul in the middle of a division: no ready, previous result kept.
      prev         = result_o;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("annul_busy", 64'(busy_o), 64'd0);
      checkOutput("annul_ready", 64'(ready_o), 64'd0);
      checkOutput("annul_result", result_o, prev);
      annul_i   = 1'b0;
      start_i   = 1'b0;
      saw_ready = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) saw_ready = 1'b1;
      end
      checkOutput("annul_no_ready", 64'(saw_ready), 64'd0);

      // Annul and start together in FREE: nothing is started.
      annul_i   = 1'b1;
      start_i   = 1'b1;
      opdata2_i = 32'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("annul_start_busy", 64'(busy_o), 64'd0);
      checkOutput("annul_start_ready", 64'(ready_o), 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);

      applyStimulus("after_annul_9_3", 1'b0, 32'd9, 32'd3, 0, {32'd0, 32'd3});

      // Asynchronous reset in the middle of a division clears outputs at once.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_mid_result", result_o, 64'd0);
      checkOutput("rst_mid_ready", 64'(ready_o), 64'd0);
      checkOutput("rst_mid_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_release_busy", 64'(busy_o), 64'd0);

      // Holding start_i in END keeps ready_o high until start_i drops.
      applyStimulus("hold_end", 1'b1, 32'hFFFFFC18, 32'd7, 4,
                    refModel(1'b1, 32'hFFFFFC18, 32'd7));
      applyStimulus("hold_end_zero", 1'b0, 32'd55, 32'd0, 3, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
